// File: rtl/alu_cmd_pkg.sv
// Shared constants, state encoding and small helpers for the ALU command
// parser that sits between the UART pair and the ALU.
package alu_cmd_pkg;

    localparam logic [7:0] CMD_CONFIG  = 8'hCD;
    localparam logic [7:0] CMD_DISPLAY = 8'hD1;

    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_SUB = 8'h22;
    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_XOR = 8'h26;
    localparam logic [7:0] OP_NOR = 8'h27;
    localparam logic [7:0] OP_SRL = 8'h02;
    localparam logic [7:0] OP_SRA = 8'h03;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_A    = 3'd1,
        ST_GET_B    = 3'd2,
        ST_GET_OP   = 3'd3,
        ST_TX_RES   = 3'd4,
        ST_WAIT_RES = 3'd5,
        ST_TX_FLG   = 3'd6,
        ST_WAIT_FLG = 3'd7
    } state_t;

    // The whole received byte is checked, so aliases in the upper bits are rejected.
    function automatic logic op_is_valid(input logic [7:0] op_byte);
        logic ok;
        case (op_byte)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRL, OP_SRA: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [7:0] pack_flags(input logic zero,
                                              input logic carry,
                                              input logic ovf);
        logic [7:0] f;
        f             = 8'h00;
        f[FLAG_ZERO]  = zero;
        f[FLAG_CARRY] = carry;
        f[FLAG_OVF]   = ovf;
        return f;
    endfunction

endpackage

// File: rtl/alu_cmd_interface_if.sv
// Bundle of the UART-side, ALU-side and status signals of the command parser.
// slave is the parser's view, master is the surrounding system's view.
interface alu_cmd_interface_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 6
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_carry;
    logic              alu_ovf;
    logic              tx_busy;
    logic              tx_done;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic [7:0]        leds;
    logic              error;

    modport slave (
        input  rx_data, rx_valid, alu_result, alu_zero, alu_carry, alu_ovf,
               tx_busy, tx_done,
        output alu_a, alu_b, alu_op, tx_data, tx_start, leds, error
    );

    modport master (
        output rx_data, rx_valid, alu_result, alu_zero, alu_carry, alu_ovf,
               tx_busy, tx_done,
        input  alu_a, alu_b, alu_op, tx_data, tx_start, leds, error
    );
endinterface

// File: rtl/alu_cmd_interface.sv
// Command parser/responder: CONFIG frames load the ALU operands atomically,
// DISPLAY answers with result and flag bytes, stale partial frames time out.
module alu_cmd_interface
    import alu_cmd_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int OP_W         = 6,
    parameter int TIMEOUT_CLKS = 1_041_600
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    alu_cmd_interface_if.slave bus
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CLKS) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

    state_t              state_r;
    state_t              state_s;
    logic [DATA_W-1:0]   shadow_a_r;
    logic [DATA_W-1:0]   shadow_a_s;
    logic [DATA_W-1:0]   shadow_b_r;
    logic [DATA_W-1:0]   shadow_b_s;
    logic [CNT_W-1:0]    tmo_cnt_r;
    logic [CNT_W-1:0]    tmo_cnt_s;
    logic                expired_s;
    logic                load_s;
    logic                error_s;
    logic                tx_start_s;
    logic [7:0]          tx_data_s;

    logic [DATA_W-1:0]   alu_a_r;
    logic [DATA_W-1:0]   alu_b_r;
    logic [OP_W-1:0]     alu_op_r;
    logic [7:0]          tx_data_r;
    logic                tx_start_r;
    logic                error_r;
    logic [7:0]          leds_r;
    logic                leds_load_r;

    // Expiry only matters inside the GET_* states; elsewhere the counter is held at zero.
    assign expired_s = (tmo_cnt_r == TMO_LAST);

    // Next-state and next-output decode for the frame parser and the responder.
    always_comb begin
        state_s    = state_r;
        shadow_a_s = shadow_a_r;
        shadow_b_s = shadow_b_r;
        tmo_cnt_s  = CNT_ZERO;
        load_s     = 1'b0;
        error_s    = 1'b0;
        tx_start_s = 1'b0;
        tx_data_s  = tx_data_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == CMD_CONFIG) begin
                        state_s = ST_GET_A;
                    end else if (bus.rx_data == CMD_DISPLAY) begin
                        state_s = ST_TX_RES;
                    end else begin
                        error_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_GET_A: begin
                if (bus.rx_valid) begin
                    shadow_a_s = DATA_W'(bus.rx_data);
                    state_s    = ST_GET_B;
                end else if (expired_s) begin
                    error_s    = 1'b1;
                    shadow_a_s = '0;
                    shadow_b_s = '0;
                    state_s    = ST_IDLE;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + CNT_ONE;
                end
            end

            ST_GET_B: begin
                if (bus.rx_valid) begin
                    shadow_b_s = DATA_W'(bus.rx_data);
                    state_s    = ST_GET_OP;
                end else if (expired_s) begin
                    error_s    = 1'b1;
                    shadow_a_s = '0;
                    shadow_b_s = '0;
                    state_s    = ST_IDLE;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + CNT_ONE;
                end
            end

            ST_GET_OP: begin
                if (bus.rx_valid) begin
                    if (op_is_valid(bus.rx_data)) begin
                        load_s = 1'b1;
                    end else begin
                        error_s = 1'b1;
                    end
                    state_s = ST_IDLE;
                end else if (expired_s) begin
                    error_s    = 1'b1;
                    shadow_a_s = '0;
                    shadow_b_s = '0;
                    state_s    = ST_IDLE;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + CNT_ONE;
                end
            end

            // Result and flags are captured in the same cycle the start pulse is issued.
            ST_TX_RES: begin
                if (!bus.tx_busy) begin
                    tx_start_s = 1'b1;
                    tx_data_s  = 8'(bus.alu_result);
                    state_s    = ST_WAIT_RES;
                end else begin
                    state_s = ST_TX_RES;
                end
            end

            ST_WAIT_RES: begin
                if (bus.tx_done) begin
                    state_s = ST_TX_FLG;
                end else begin
                    state_s = ST_WAIT_RES;
                end
            end

            ST_TX_FLG: begin
                if (!bus.tx_busy) begin
                    tx_start_s = 1'b1;
                    tx_data_s  = pack_flags(bus.alu_zero, bus.alu_carry, bus.alu_ovf);
                    state_s    = ST_WAIT_FLG;
                end else begin
                    state_s = ST_TX_FLG;
                end
            end

            ST_WAIT_FLG: begin
                if (bus.tx_done) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_FLG;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Parser state, shadow operands and inactivity counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            shadow_a_r <= '0;
            shadow_b_r <= '0;
            tmo_cnt_r  <= CNT_ZERO;
        end else begin
            state_r    <= state_s;
            shadow_a_r <= shadow_a_s;
            shadow_b_r <= shadow_b_s;
            tmo_cnt_r  <= tmo_cnt_s;
        end
    end

    // Operand/opcode registers update together so the ALU never sees a mixed frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            alu_a_r  <= '0;
            alu_b_r  <= '0;
            alu_op_r <= '0;
        end else if (load_s) begin
            alu_a_r  <= shadow_a_r;
            alu_b_r  <= shadow_b_r;
            alu_op_r <= bus.rx_data[OP_W-1:0];
        end
    end

    // LEDs latch the ALU result one cycle after new operands become visible.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            leds_load_r <= 1'b0;
            leds_r      <= 8'h00;
        end else begin
            leds_load_r <= load_s;
            if (leds_load_r) begin
                leds_r <= 8'(bus.alu_result);
            end
        end
    end

    // Transmit byte, start pulse and error pulse registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_data_r  <= 8'h00;
            tx_start_r <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            tx_data_r  <= tx_data_s;
            tx_start_r <= tx_start_s;
            error_r    <= error_s;
        end
    end

    assign bus.alu_a    = alu_a_r;
    assign bus.alu_b    = alu_b_r;
    assign bus.alu_op   = alu_op_r;
    assign bus.tx_data  = tx_data_r;
    assign bus.tx_start = tx_start_r;
    assign bus.leds     = leds_r;
    assign bus.error    = error_r;

endmodule

// File: tb/tb_alu_cmd_interface.sv
// Self-checking bench: behavioural ALU and UART-tx models around the parser,
// table-driven frames, hand-written corner sequences and random frames.
module tb_alu_cmd_interface;
    import alu_cmd_pkg::*;

    localparam int TMO = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_cmd_interface_if #(.DATA_W(8), .OP_W(6)) bus ();

    alu_cmd_interface #(.DATA_W(8), .OP_W(6), .TIMEOUT_CLKS(TMO)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    int err_cnt = 0;
    int viol    = 0;

    // Behavioural ALU: returns {ovf, carry, zero, result}.
    function automatic logic [10:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [5:0] op);
        logic [8:0] w;
        logic [7:0] r;
        logic c, v;
        w = 9'd0; r = 8'd0; c = 1'b0; v = 1'b0;
        case (op)
            6'h20: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                         v = (a[7] == b[7]) && (r[7] != a[7]); end
            6'h22: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8];
                         v = (a[7] != b[7]) && (r[7] != a[7]); end
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h02: r = a >> b[2:0];
            6'h03: r = 8'($signed(a) >>> b[2:0]);
            default: r = 8'd0;
        endcase
        return {v, c, (r == 8'd0), r};
    endfunction

    logic [10:0] alu_out;
    always_comb alu_out = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);
    assign bus.alu_result = alu_out[7:0];
    assign bus.alu_zero   = alu_out[8];
    assign bus.alu_carry  = alu_out[9];
    assign bus.alu_ovf    = alu_out[10];

    // UART transmitter model: each byte keeps busy high for 5 cycles, then done pulses.
    logic model_busy = 1'b0;
    logic hold_busy  = 1'b0;
    logic done_m     = 1'b0;
    int   tx_cnt     = 0;
    logic [7:0] txq[$];
    assign bus.tx_busy = model_busy | hold_busy;
    assign bus.tx_done = done_m;

    always @(posedge clk) begin
        done_m <= 1'b0;
        if (bus.tx_start) begin
            if (bus.tx_busy) viol <= viol + 1;
            txq.push_back(bus.tx_data);
            model_busy <= 1'b1;
            tx_cnt     <= 5;
        end else if (model_busy) begin
            if (tx_cnt == 1) begin
                model_busy <= 1'b0;
                done_m     <= 1'b1;
            end
            tx_cnt <= tx_cnt - 1;
        end
    end

    always @(negedge clk) if (bus.error) err_cnt <= err_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_config(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] op, input int max_gap);
        send_byte(CMD_CONFIG);
        tick($urandom_range(0, max_gap));
        send_byte(a);
        tick($urandom_range(0, max_gap));
        send_byte(b);
        tick($urandom_range(0, max_gap));
        send_byte(op);
    endtask

    task automatic wait_txq(input int want, input string nm);
        int n;
        n = 0;
        while (txq.size() < want && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (txq.size() < want) begin
            total++;
            bad++;
            $display("FAIL %s: got %0d tx bytes expected %0d (timeout)", nm, txq.size(), want);
        end
    endtask

    task automatic wait_tx_idle();
        int n;
        n = 0;
        while (model_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        tick(3);
    endtask

    task automatic display_check(input string nm, input logic [7:0] xres, input logic [7:0] xflg);
        int e0;
        e0 = err_cnt;
        txq.delete();
        send_byte(CMD_DISPLAY);
        wait_txq(2, {nm, "_txcount"});
        if (txq.size() >= 2) begin
            check8({nm, "_res"}, txq[0], xres);
            check8({nm, "_flg"}, txq[1], xflg);
        end
        wait_tx_idle();
        check_int({nm, "_noerr"}, err_cnt - e0, 0);
        txq.delete();
    endtask

    typedef struct {
        logic [7:0] a, b, op;
        logic [7:0] xa, xb, xop, xres, xflg;
        int         xerr;
    } vec_t;

    vec_t tbl[10];
    logic [7:0] valid_ops[8];
    logic [7:0] bad_ops[5];
    logic [7:0] m_a, m_b, m_leds;
    logic [5:0] m_op;

    task automatic check_regs(input string nm);
        check8({nm, "_a"}, bus.alu_a, m_a);
        check8({nm, "_b"}, bus.alu_b, m_b);
        check8({nm, "_op"}, 8'(bus.alu_op), 8'(m_op));
        check8({nm, "_leds"}, bus.leds, m_leds);
    endtask

    initial begin
        int e0;
        int n;
        logic [10:0] r;
        logic [7:0] a, b, op;
        logic v;

        tbl[0] = '{8'h05, 8'h0A, 8'h20, 8'h05, 8'h0A, 8'h20, 8'h0F, 8'h00, 0};
        tbl[1] = '{8'h64, 8'h64, 8'h22, 8'h64, 8'h64, 8'h22, 8'h00, 8'h01, 0};
        tbl[2] = '{8'h64, 8'h32, 8'h20, 8'h64, 8'h32, 8'h20, 8'h96, 8'h04, 0};
        tbl[3] = '{8'h05, 8'h0A, 8'h3F, 8'h64, 8'h32, 8'h20, 8'h96, 8'h04, 1};
        tbl[4] = '{8'hFF, 8'h01, 8'h20, 8'hFF, 8'h01, 8'h20, 8'h00, 8'h03, 0};
        tbl[5] = '{8'h01, 8'h02, 8'h22, 8'h01, 8'h02, 8'h22, 8'hFF, 8'h02, 0};
        tbl[6] = '{8'hF0, 8'h3C, 8'h24, 8'hF0, 8'h3C, 8'h24, 8'h30, 8'h00, 0};
        tbl[7] = '{8'h80, 8'h01, 8'h03, 8'h80, 8'h01, 8'h03, 8'hC0, 8'h00, 0};
        tbl[8] = '{8'hCD, 8'hD1, 8'h27, 8'hCD, 8'hD1, 8'h27, 8'h22, 8'h00, 0};
        tbl[9] = '{8'h81, 8'h04, 8'h02, 8'h81, 8'h04, 8'h02, 8'h08, 8'h00, 0};
        valid_ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};
        bad_ops   = '{8'h3F, 8'h21, 8'h00, 8'hCD, 8'h60};

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        tick(3);
        m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_leds = 8'h00;
        check_regs("reset");
        check8("reset_txdata", bus.tx_data, 8'h00);
        check8("reset_txstart", 8'(bus.tx_start), 8'h00);
        check8("reset_error", 8'(bus.error), 8'h00);
        rst_n = 1'b1;
        tick(2);

        // Table-driven frames followed by a DISPLAY read-back.
        for (int i = 0; i < 10; i++) begin
            e0 = err_cnt;
            send_config(tbl[i].a, tbl[i].b, tbl[i].op, 0);
            tick(3);
            check8($sformatf("tbl%0d_a", i), bus.alu_a, tbl[i].xa);
            check8($sformatf("tbl%0d_b", i), bus.alu_b, tbl[i].xb);
            check8($sformatf("tbl%0d_op", i), 8'(bus.alu_op), tbl[i].xop);
            check8($sformatf("tbl%0d_leds", i), bus.leds, tbl[i].xres);
            check_int($sformatf("tbl%0d_err", i), err_cnt - e0, tbl[i].xerr);
            display_check($sformatf("tbl%0d_disp", i), tbl[i].xres, tbl[i].xflg);
        end
        m_a = 8'h81; m_b = 8'h04; m_op = 6'h02; m_leds = 8'h08;

        // Partial frame left idle must time out; the following byte is then a bad command.
        e0 = err_cnt;
        send_byte(CMD_CONFIG);
        send_byte(8'h05);
        n = 0;
        while (err_cnt == e0 && n < TMO + 20) begin
            @(negedge clk);
            n++;
        end
        tick(2);
        check_int("tmo_fire", err_cnt - e0, 1);
        check_int("tmo_not_early", (n >= TMO - 3) ? 1 : 0, 1);
        e0 = err_cnt;
        send_byte(8'h0A);
        tick(3);
        check_int("tmo_after_byte_err", err_cnt - e0, 1);
        check_regs("tmo_regs");

        // Gaps just under the timeout keep the frame alive.
        e0 = err_cnt;
        send_byte(CMD_CONFIG); tick(TMO - 5);
        send_byte(8'h12);      tick(TMO - 5);
        send_byte(8'h34);      tick(TMO - 5);
        send_byte(8'h26);      tick(3);
        m_a = 8'h12; m_b = 8'h34; m_op = 6'h26; m_leds = 8'h26;
        check_int("slow_frame_noerr", err_cnt - e0, 0);
        check_regs("slow_frame");

        // DISPLAY while the transmitter is busy must wait for it.
        hold_busy = 1'b1;
        txq.delete();
        send_byte(CMD_DISPLAY);
        tick(20);
        check_int("busy_hold_nostart", txq.size(), 0);
        hold_busy = 1'b0;
        wait_txq(2, "busy_release");
        if (txq.size() >= 2) begin
            check8("busy_release_res", txq[0], 8'h26);
            check8("busy_release_flg", txq[1], 8'h00);
        end
        wait_tx_idle();
        txq.delete();

        // Bytes arriving while responding are dropped without error.
        e0 = err_cnt;
        send_byte(CMD_DISPLAY);
        wait_txq(1, "stray_first");
        send_byte(CMD_CONFIG);
        send_byte(8'h33);
        wait_txq(2, "stray_second");
        if (txq.size() >= 2) begin
            check8("stray_res", txq[0], 8'h26);
            check8("stray_flg", txq[1], 8'h00);
        end
        wait_tx_idle();
        txq.delete();
        check_int("stray_noerr", err_cnt - e0, 0);
        check_regs("stray_regs");

        // Asynchronous reset while waiting for the first byte to finish.
        send_byte(CMD_DISPLAY);
        wait_txq(1, "rst_mid_first");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_leds = 8'h00;
        check_regs("rst_mid");
        check8("rst_mid_txdata", bus.tx_data, 8'h00);
        check8("rst_mid_error", 8'(bus.error), 8'h00);
        tick(2);
        rst_n = 1'b1;
        e0 = err_cnt;
        wait_tx_idle();
        tick(5);
        check_int("rst_mid_no_second", txq.size(), 1);
        check_int("rst_mid_noerr", err_cnt - e0, 0);
        txq.delete();
        display_check("post_rst_disp", 8'h00, 8'h01);

        // Random frames against the reference model.
        for (int it = 0; it < 30; it++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                op = bad_ops[$urandom_range(0, 4)];
            end else begin
                op = valid_ops[$urandom_range(0, 7)];
            end
            v = 1'b0;
            foreach (valid_ops[k]) if (valid_ops[k] == op) v = 1'b1;
            e0 = err_cnt;
            send_config(a, b, op, 2);
            tick(3);
            if (v) begin
                m_a = a; m_b = b; m_op = op[5:0];
                r = alu_ref(m_a, m_b, m_op);
                m_leds = r[7:0];
            end
            check_int($sformatf("rnd%0d_err", it), err_cnt - e0, v ? 0 : 1);
            check_regs($sformatf("rnd%0d", it));
            if (it % 3 == 0) begin
                r = alu_ref(m_a, m_b, m_op);
                display_check($sformatf("rnd%0d_disp", it), r[7:0], {5'b00000, r[10:8]});
            end
        end

        check_int("start_while_busy", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
